// File: rtl/pps1_trig_gen.sv
// pps1_trig_gen
// PPS-locked trigger generator running entirely in the clk250 domain.
// A qualified PPS pulse loads a delay counter. When the counter expires,
// a single-cycle trigger is emitted. The block also measures the PPS period,
// counts issued triggers and flags PPS pulses that re-armed a pending delay.

module pps1_trig_gen #(
    parameter int DELAY_WIDTH  = 32,
    parameter int PERIOD_WIDTH = 32,
    parameter int COUNT_WIDTH  = 16
) (
    input  logic                    clk250_i,
    input  logic                    rst_n_i,
    input  logic                    pps_i,
    input  logic                    en_i,
    input  logic                    disable_i,
    input  logic [DELAY_WIDTH-1:0]  pps_time_i,
    input  logic                    clr_missed_i,
    output logic                    trig_o,
    output logic [PERIOD_WIDTH-1:0] pps_period_o,
    output logic                    period_valid_o,
    output logic                    missed_o,
    output logic [COUNT_WIDTH-1:0]  trig_count_o
);

    localparam logic [DELAY_WIDTH-1:0]  DELAY_ONE  = DELAY_WIDTH'(1);
    localparam logic [PERIOD_WIDTH-1:0] PERIOD_ONE = PERIOD_WIDTH'(1);
    localparam logic [PERIOD_WIDTH-1:0] PERIOD_MAX = '1;
    localparam logic [COUNT_WIDTH-1:0]  COUNT_ONE  = COUNT_WIDTH'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } state_t;

    state_t                  state;
    logic [DELAY_WIDTH-1:0]  dcnt;
    logic [PERIOD_WIDTH-1:0] pcnt;
    logic                    pps_seen;

    logic arm;
    logic abort;
    logic expired;

    // A PPS only starts a delay when triggering is enabled and not masked.
    // Abort and arm are mutually exclusive, so abort can safely be checked first.
    assign arm     = pps_i && en_i && !disable_i;
    assign abort   = !en_i || disable_i;
    assign expired = (dcnt == '0);

    // Trigger state machine: delay countdown, trigger pulse, trigger count and missed flag.
    always_ff @(posedge clk250_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state        <= IDLE;
            dcnt         <= '0;
            trig_o       <= 1'b0;
            trig_count_o <= '0;
            missed_o     <= 1'b0;
        end else begin
            trig_o <= 1'b0;

            if (clr_missed_i) begin
                missed_o <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (arm) begin
                        dcnt  <= pps_time_i;
                        state <= ARMED;
                    end
                end

                ARMED: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (expired) begin
                        trig_o       <= 1'b1;
                        trig_count_o <= trig_count_o + COUNT_ONE;
                        if (arm) begin
                            dcnt  <= pps_time_i;
                            state <= ARMED;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (arm) begin
                        dcnt     <= pps_time_i;
                        missed_o <= 1'b1;
                    end else begin
                        dcnt <= dcnt - DELAY_ONE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Period measurement: a saturating counter restarted by every PPS, captured from the second PPS onwards.
    always_ff @(posedge clk250_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pcnt           <= '0;
            pps_seen       <= 1'b0;
            pps_period_o   <= '0;
            period_valid_o <= 1'b0;
        end else begin
            if (pps_i) begin
                pcnt     <= '0;
                pps_seen <= 1'b1;
                if (pps_seen) begin
                    period_valid_o <= 1'b1;
                    if (pcnt == PERIOD_MAX) begin
                        pps_period_o <= PERIOD_MAX;
                    end else begin
                        pps_period_o <= pcnt + PERIOD_ONE;
                    end
                end
            end else if (pcnt != PERIOD_MAX) begin
                pcnt <= pcnt + PERIOD_ONE;
            end
        end
    end

endmodule

// File: tb/tb_pps1_trig_gen.sv
// Testbench for pps1_trig_gen.
// Expected trigger cycles are queued when a PPS is driven. A monitor pops one
// entry per observed trig_o pulse. Narrow period and count widths keep
// saturation and wrap reachable in a short run.

module tb_pps1_trig_gen;

    localparam int DW = 32;
    localparam int PW = 12;
    localparam int CW = 8;
    localparam int unsigned PERIOD_SAT = (1 << PW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          pps = 1'b0;
    logic          en = 1'b0;
    logic          dis = 1'b0;
    logic [DW-1:0] pps_time = '0;
    logic          clr_missed = 1'b0;

    logic          trig;
    logic [PW-1:0] pps_period;
    logic          period_valid;
    logic          missed;
    logic [CW-1:0] trig_count;

    int unsigned   cyc = 0;
    int            checks = 0;
    int            errors = 0;
    int unsigned   exp_q[$];
    logic [CW-1:0] exp_count = '0;
    int            pps_seen = 0;
    int unsigned   last_pps = 0;
    int unsigned   mon_exp;
    int unsigned   c0;

    pps1_trig_gen #(
        .DELAY_WIDTH (DW),
        .PERIOD_WIDTH(PW),
        .COUNT_WIDTH (CW)
    ) dut (
        .clk250_i      (clk),
        .rst_n_i       (rst_n),
        .pps_i         (pps),
        .en_i          (en),
        .disable_i     (dis),
        .pps_time_i    (pps_time),
        .clr_missed_i  (clr_missed),
        .trig_o        (trig),
        .pps_period_o  (pps_period),
        .period_valid_o(period_valid),
        .missed_o      (missed),
        .trig_count_o  (trig_count)
    );

    // Free-running clock
    always #2 clk = ~clk;

    // Cycle index: inputs driven just after posedge k belong to cycle k
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) tick();
    endtask

    task automatic waitUntil(input int unsigned c);
        while (cyc < c) tick();
    endtask

    // Drive one PPS cycle, queue the expected trigger and check the period outputs one cycle later
    task automatic applyStimulus(input logic [DW-1:0] t, input bit rearm);
        int unsigned c;
        int unsigned d;
        c = cyc;
        pps = 1'b1;
        pps_time = t;
        if (en && !dis) begin
            if (rearm && exp_q.size() != 0) void'(exp_q.pop_back());
            exp_q.push_back(c + 2 + t);
        end
        tick();
        pps = 1'b0;
        @(negedge clk);
        checkOutput("period_valid", {63'd0, period_valid}, (pps_seen >= 1) ? 64'd1 : 64'd0);
        if (pps_seen >= 1) begin
            d = c - last_pps;
            if (d > PERIOD_SAT) d = PERIOD_SAT;
            checkOutput("pps_period", {52'd0, pps_period}, {32'd0, d});
        end
        last_pps = c;
        pps_seen++;
    endtask

    // Wait for all queued triggers to appear within a cycle budget
    task automatic drainTriggers(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        checkOutput("trig_drain", exp_q.size(), 64'd0);
        exp_q.delete();
    endtask

    task automatic checkResetValues(input string tag);
        @(negedge clk);
        checkOutput({tag, "_trig"}, {63'd0, trig}, 64'd0);
        checkOutput({tag, "_period"}, {52'd0, pps_period}, 64'd0);
        checkOutput({tag, "_valid"}, {63'd0, period_valid}, 64'd0);
        checkOutput({tag, "_missed"}, {63'd0, missed}, 64'd0);
        checkOutput({tag, "_count"}, {56'd0, trig_count}, 64'd0);
    endtask

    // Scoreboard monitor: every trigger pulse must match the oldest queued cycle
    always @(negedge clk) begin
        if (trig !== 1'b0) begin
            if (exp_q.size() == 0) begin
                checkOutput("spurious_trig", {63'd0, trig}, 64'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                checkOutput("trig_cycle", cyc, mon_exp);
                exp_count = exp_count + 1'b1;
                checkOutput("trig_count", {56'd0, trig_count}, {56'd0, exp_count});
            end
        end
    end

    // Watchdog
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not complete, errors so far %0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        $display("[TB] starting");
        waitCycles(3);
        checkResetValues("reset");
        rst_n = 1'b1;
        tick();

        // Basic delay; a later pps_time change must not affect the pending delay
        en = 1'b1;
        waitUntil(10);
        applyStimulus(100, 1'b0);
        pps_time = 7;
        drainTriggers(200);
        checkOutput("count_basic", {56'd0, trig_count}, 64'd1);

        // Period measurement and saturation, with triggering disabled
        en = 1'b0;
        c0 = cyc;
        applyStimulus(0, 1'b0);
        waitUntil(c0 + 2500);
        applyStimulus(0, 1'b0);
        waitUntil(c0 + 5000);
        applyStimulus(0, 1'b0);
        waitUntil(c0 + 10000);
        applyStimulus(0, 1'b0);
        waitUntil(c0 + 10300);
        applyStimulus(0, 1'b0);

        // Re-arm: the first delay is dropped, missed is sticky until cleared
        en = 1'b1;
        c0 = cyc;
        applyStimulus(1000, 1'b0);
        waitUntil(c0 + 500);
        applyStimulus(1000, 1'b1);
        checkOutput("missed_set", {63'd0, missed}, 64'd1);
        drainTriggers(1600);
        checkOutput("missed_sticky", {63'd0, missed}, 64'd1);
        clr_missed = 1'b1;
        tick();
        clr_missed = 1'b0;
        @(negedge clk);
        checkOutput("missed_clr", {63'd0, missed}, 64'd0);

        // Set wins over clear in the same cycle
        c0 = cyc;
        applyStimulus(100, 1'b0);
        waitUntil(c0 + 10);
        clr_missed = 1'b1;
        applyStimulus(100, 1'b1);
        clr_missed = 1'b0;
        checkOutput("missed_set_prio", {63'd0, missed}, 64'd1);
        drainTriggers(200);
        clr_missed = 1'b1;
        tick();
        clr_missed = 1'b0;

        // Expiry and PPS in the same cycle: fire, reload, no missed
        c0 = cyc;
        applyStimulus(5, 1'b0);
        waitUntil(c0 + 6);
        applyStimulus(4, 1'b0);
        checkOutput("missed_fire_pps", {63'd0, missed}, 64'd0);
        drainTriggers(50);
        checkOutput("missed_fire_pps2", {63'd0, missed}, 64'd0);

        // Abort by disable
        c0 = cyc;
        applyStimulus(50, 1'b0);
        void'(exp_q.pop_back());
        waitUntil(c0 + 20);
        dis = 1'b1;
        waitCycles(2);
        dis = 1'b0;
        waitCycles(60);
        checkOutput("abort_dis_count", {56'd0, trig_count}, {56'd0, exp_count});

        // Abort by enable drop
        c0 = cyc;
        applyStimulus(50, 1'b0);
        void'(exp_q.pop_back());
        waitUntil(c0 + 20);
        en = 1'b0;
        tick();
        en = 1'b1;
        waitCycles(60);
        checkOutput("abort_en_count", {56'd0, trig_count}, {56'd0, exp_count});

        // Abort wins over expiry in the same cycle
        c0 = cyc;
        applyStimulus(3, 1'b0);
        void'(exp_q.pop_back());
        waitUntil(c0 + 4);
        dis = 1'b1;
        tick();
        dis = 1'b0;
        waitCycles(10);
        checkOutput("abort_prio_count", {56'd0, trig_count}, {56'd0, exp_count});

        // PPS while disabled does not arm but still updates the period
        dis = 1'b1;
        applyStimulus(2, 1'b0);
        waitCycles(10);
        dis = 1'b0;
        checkOutput("dis_pps_count", {56'd0, trig_count}, {56'd0, exp_count});

        // Reset mid-delay drops the pending trigger
        c0 = cyc;
        applyStimulus(100, 1'b0);
        waitUntil(c0 + 30);
        rst_n = 1'b0;
        exp_q.delete();
        exp_count = '0;
        pps_seen = 0;
        waitUntil(c0 + 40);
        checkResetValues("midreset");
        rst_n = 1'b1;
        waitCycles(150);
        checkOutput("midreset_count", {56'd0, trig_count}, 64'd0);
        checkOutput("midreset_valid", {63'd0, period_valid}, 64'd0);

        // Zero delay, back-to-back PPS, count wrap
        for (int i = 0; i < (1 << CW); i++) begin
            applyStimulus(0, 1'b0);
            tick();
        end
        drainTriggers(20);
        checkOutput("wrap_count", {56'd0, trig_count}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
